// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selector with a boot cycle, stall hold and sticky misalignment fault.
// Optional redirect counter enabled by defining PC_REDIRECT_COUNT_EN.
module pc_fetch_unit #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             inClk,
  input  logic             inReset,
  input  logic [1:0]       inPCsrc,
  input  logic [15:0]      inImm,
  input  logic [25:0]      inJumpIdx,
  input  logic [WIDTH-1:0] inRegTarget,
  input  logic             inStall,
  output logic [WIDTH-1:0] outPC,
  output logic [WIDTH-1:0] outPCplus4,
  output logic             outValid,
  output logic             outFault,
`ifdef PC_REDIRECT_COUNT_EN
  output logic [15:0]      outRedirects,
`endif
  output logic [WIDTH-1:0] outFaultPC
);

  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic [WIDTH-1:0] plus4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] target;
  logic             update;
  logic             misaligned;

  assign plus4  = pc_q + WIDTH'(4);
  assign br_off = {{(WIDTH-18){inImm[15]}}, inImm, 2'b00};

  always_comb begin
    target = plus4;
    unique case (inPCsrc)
      2'b00: target = plus4;
      2'b01: target = {plus4[WIDTH-1:WIDTH-4], inJumpIdx, 2'b00};
      2'b10: target = plus4 + br_off;
      2'b11: target = inRegTarget;
      default: target = plus4;
    endcase
  end

  assign update     = (state_q == StRun) && !inStall;
  assign misaligned = (target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (update) begin
          if (misaligned) begin
            state_d    = StFault;
            fault_pc_d = target;
          end else begin
            pc_d = target;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] redirects_q, redirects_d;

  // Counts only taken non-sequential updates that commit; saturates.
  always_comb begin
    redirects_d = redirects_q;
    if (update && (inPCsrc != 2'b00) && !misaligned && (redirects_q != 16'hFFFF)) begin
      redirects_d = redirects_q + 16'd1;
    end
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      redirects_q <= '0;
    end else begin
      redirects_q <= redirects_d;
    end
  end

  assign outRedirects = redirects_q;
`endif

  assign outPC      = pc_q;
  assign outPCplus4 = plus4;
  assign outValid   = (state_q == StRun);
  assign outFault   = (state_q == StFault);
  assign outFaultPC = fault_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; covers the redirect counter when
// PC_REDIRECT_COUNT_EN is defined.
module tb_pc_fetch_unit;

  logic        inClk;
  logic        inReset;
  logic [1:0]  inPCsrc;
  logic [15:0] inImm;
  logic [25:0] inJumpIdx;
  logic [31:0] inRegTarget;
  logic        inStall;
  logic [31:0] outPC;
  logic [31:0] outPCplus4;
  logic        outValid;
  logic        outFault;
  logic [31:0] outFaultPC;
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] outRedirects;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  pc_fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .inClk       (inClk),
    .inReset     (inReset),
    .inPCsrc     (inPCsrc),
    .inImm       (inImm),
    .inJumpIdx   (inJumpIdx),
    .inRegTarget (inRegTarget),
    .inStall     (inStall),
    .outPC       (outPC),
    .outPCplus4  (outPCplus4),
    .outValid    (outValid),
    .outFault    (outFault),
`ifdef PC_REDIRECT_COUNT_EN
    .outRedirects(outRedirects),
`endif
    .outFaultPC  (outFaultPC)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    inReset     = 1'b1;
    inPCsrc     = 2'b00;
    inImm       = 16'h0000;
    inJumpIdx   = 26'h0;
    inRegTarget = 32'h0;
    inStall     = 1'b0;

    #12;
    check("rst_pc", outPC, 32'h0);
    check("rst_plus4", outPCplus4, 32'h4);
    check("rst_valid", {31'b0, outValid}, 32'h0);
    check("rst_fault", {31'b0, outFault}, 32'h0);
    check("rst_faultpc", outFaultPC, 32'h0);
    inReset = 1'b0;

    step();
    check("boot_valid", {31'b0, outValid}, 32'h1);
    check("boot_pc", outPC, 32'h0);

    step();
    check("seq_pc", outPC, 32'h4);
    check("seq_plus4", outPCplus4, 32'h8);

    repeat (3) step();
    check("seq_to_10", outPC, 32'h10);

    inPCsrc = 2'b10; inImm = 16'hFFFC;
    step();
    check("br_neg", outPC, 32'h4);

    inPCsrc = 2'b00;
    repeat (3) step();
    check("seq_back_10", outPC, 32'h10);

    inPCsrc = 2'b10; inImm = 16'h0003;
    step();
    check("br_pos", outPC, 32'h20);

    inPCsrc = 2'b11; inRegTarget = 32'h4000_0008;
    step();
    check("jr_aligned", outPC, 32'h4000_0008);

    inPCsrc = 2'b01; inJumpIdx = 26'h0000100;
    step();
    check("jump", outPC, 32'h4000_0400);
    check("jump_valid", {31'b0, outValid}, 32'h1);

    inStall = 1'b1; inImm = 16'h0003; inRegTarget = 32'h0000_1002;
    for (int i = 0; i < 3; i++) begin
      inPCsrc = (i == 2) ? 2'b11 : 2'b10;
      step();
      check("stall_pc", outPC, 32'h4000_0400);
      check("stall_nofault", {31'b0, outFault}, 32'h0);
    end

    inStall = 1'b0; inPCsrc = 2'b00;
    step();
    check("stall_release", outPC, 32'h4000_0404);

    inPCsrc = 2'b11; inRegTarget = 32'hFFFF_FFFC;
    step();
    check("jr_top", outPC, 32'hFFFF_FFFC);
    check("top_plus4_wrap", outPCplus4, 32'h0);

    inPCsrc = 2'b00;
    step();
    check("seq_wrap", outPC, 32'h0);

    inPCsrc = 2'b10; inImm = 16'hFFFE;
    step();
    check("br_wrap_below0", outPC, 32'hFFFF_FFFC);
    check("br_wrap_nofault", {31'b0, outFault}, 32'h0);

    inPCsrc = 2'b11; inRegTarget = 32'h0000_1002;
    step();
    check("fault_flag", {31'b0, outFault}, 32'h1);
    check("fault_pc_cap", outFaultPC, 32'h0000_1002);
    check("fault_valid", {31'b0, outValid}, 32'h0);
    check("fault_pc_hold", outPC, 32'hFFFF_FFFC);

    inPCsrc = 2'b00;
    repeat (2) step();
    check("fault_absorb_pc", outPC, 32'hFFFF_FFFC);
    check("fault_absorb_flag", {31'b0, outFault}, 32'h1);

    inPCsrc = 2'b11; inRegTarget = 32'h0000_2000;
    step();
    check("fault_absorb_jr", outPC, 32'hFFFF_FFFC);
    check("fault_absorb_cap", outFaultPC, 32'h0000_1002);

    // Asynchronous reset away from any clock edge.
    #2;
    inReset = 1'b1;
    #1;
    check("async_rst_pc", outPC, 32'h0);
    check("async_rst_fault", {31'b0, outFault}, 32'h0);
    check("async_rst_faultpc", outFaultPC, 32'h0);
    check("async_rst_valid", {31'b0, outValid}, 32'h0);
    inPCsrc = 2'b00;
    #1;
    inReset = 1'b0;

`ifdef PC_REDIRECT_COUNT_EN
    check("cnt_rst", {16'b0, outRedirects}, 32'h0);
    step();
    inPCsrc = 2'b10; inImm = 16'h0000;
    repeat (2) step();
    inPCsrc = 2'b01; inJumpIdx = 26'h0000040;
    step();
    inStall = 1'b1;
    step();
    inStall = 1'b0; inPCsrc = 2'b00;
    repeat (2) step();
    check("cnt_three", {16'b0, outRedirects}, 32'h3);
    #3;
    inReset = 1'b1;
    #1;
    check("cnt_async_rst", {16'b0, outRedirects}, 32'h0);
    #1;
    inReset = 1'b0;
`else
    step();
    check("reboot_valid", {31'b0, outValid}, 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
